mux4to1_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the 4:1 behavioural multiplexer datapath among four requesters. It owns the mux select, grants one requester at a time with a bounded hold time, and presents the granted input on `out` with a `valid` qualifier. It sits directly in front of the 4:1 mux stage and replaces the static `sel` drive.

---
 rtl/mux4to1_rr_arbiter.sv | 108 ++++++++++
 tb/tb_mux4to1_rr_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mux4to1_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 mux, with bounded hold time per grant.
// Optional MUX_ARB_LOCK_EN adds a `lock` input that suppresses hold-time expiry.
module mux4to1_rr_arbiter #(
  parameter int unsigned W       = 1,
  parameter int unsigned MAXHOLD = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] in,
`ifdef MUX_ARB_LOCK_EN
  input  logic           lock,
`endif
  output logic [3:0]     gnt,
  output logic [1:0]     sel,
  output logic [W-1:0]   out,
  output logic           valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] holdcnt_q, holdcnt_d;

  logic       lock_eff;
  logic       found;
  logic [1:0] win;
  logic [1:0] idx;
  logic       release_pt;

`ifdef MUX_ARB_LOCK_EN
  assign lock_eff = lock;
`else
  assign lock_eff = 1'b0;
`endif

  // First requester found scanning upward from ptr_q (mod 4).
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    holdcnt_d  = holdcnt_q;
    release_pt = 1'b0;

    case (state_q)
      IDLE:    release_pt = 1'b1;
      GRANT:   release_pt = !req[sel_q] || ((holdcnt_q == HOLD_LAST) && !lock_eff);
      default: release_pt = 1'b1;
    endcase

    if (release_pt) begin
      if (found) begin
        state_d   = GRANT;
        gnt_d     = 4'b0001 << win;
        sel_d     = win;
        ptr_d     = win + 2'd1;
        holdcnt_d = '0;
      end else begin
        // Going idle keeps sel at its last value.
        state_d = IDLE;
        gnt_d   = '0;
      end
    end else if (holdcnt_q != HOLD_LAST) begin
      holdcnt_d = holdcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      holdcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      holdcnt_q <= holdcnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = |gnt_q;
  assign out   = valid ? in[sel_q*W +: W] : '0;

endmodule

// File: tb/tb_mux4to1_rr_arbiter.sv
// Scoreboard bench for mux4to1_rr_arbiter: directed vectors push expected outputs, a monitor compares.
module tb_mux4to1_rr_arbiter;

  localparam logic [15:0] IN_C = 16'hDCBA;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] out;
    string      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] in_bus = IN_C;
  logic        lock = 1'b0;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [3:0]  out;
  logic        valid;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mux4to1_rr_arbiter #(.W(4), .MAXHOLD(4)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .req   (req),
    .in    (in_bus),
`ifdef MUX_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .sel   (sel),
    .out   (out),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the DUT must show after the next edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic lk,
                      input logic [3:0] egnt, input logic [1:0] esel, input string tag);
    exp_t       e;
    logic [15:0] slices;
    @(negedge clk);
    rstn = r;
    req  = rq;
    lock = lk;
    slices  = IN_C;
    e.gnt   = egnt;
    e.sel   = esel;
    e.valid = |egnt;
    e.out   = (|egnt) ? slices[esel*4 +: 4] : 4'h0;
    e.tag   = tag;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if (gnt !== e.gnt || sel !== e.sel || valid !== e.valid || out !== e.out) begin
        n_fail++;
        $display("FAIL %s: got gnt=%b sel=%0d valid=%b out=%h, expected gnt=%b sel=%0d valid=%b out=%h",
                 e.tag, gnt, sel, valid, out, e.gnt, e.sel, e.valid, e.out);
      end
    end
  end

  initial begin
    // Reset held with all requests pending, then first grant goes to 0.
    step(0, 4'hF, 0, 4'b0000, 0, "reset0");
    step(0, 4'hF, 0, 4'b0000, 0, "reset1");
    step(1, 4'hF, 0, 4'b0001, 0, "first_grant");

    // Lone requester keeps the grant across expiry.
    step(0, 4'h0, 0, 4'b0000, 0, "rst_single");
    for (int i = 0; i < 12; i++) step(1, 4'b0100, 0, 4'b0100, 2, "single");
    step(1, 4'b0000, 0, 4'b0000, 2, "single_idle");

    // All requesting: 4-cycle slots 0,1,2,3,0.
    step(0, 4'h0, 0, 4'b0000, 0, "rst_all");
    for (int i = 0; i < 20; i++) begin
      logic [1:0] g;
      g = 2'(i / 4);
      step(1, 4'b1111, 0, 4'b0001 << g, g, "all_req");
    end

    // Early release hands over on the edge after the drop.
    step(0, 4'h0, 0, 4'b0000, 0, "rst_early");
    step(1, 4'b0011, 0, 4'b0001, 0, "early_g0a");
    step(1, 4'b0011, 0, 4'b0001, 0, "early_g0b");
    step(1, 4'b0010, 0, 4'b0010, 1, "early_handover");
    step(1, 4'b0010, 0, 4'b0010, 1, "early_hold1");
    step(1, 4'b0000, 0, 4'b0000, 1, "early_idle");

    // Reset mid-grant clears ptr, so index 1 wins next.
    step(0, 4'h0, 0, 4'b0000, 0, "rst_mid_pre");
    step(1, 4'b0100, 0, 4'b0100, 2, "mid_g2");
    step(0, 4'b1010, 0, 4'b0000, 0, "mid_reset");
    step(1, 4'b1010, 0, 4'b0010, 1, "mid_after");

`ifdef MUX_ARB_LOCK_EN
    step(0, 4'h0, 0, 4'b0000, 0, "rst_lock");
    for (int i = 0; i < 10; i++) step(1, 4'b0011, 1, 4'b0001, 0, "lock_hold");
    step(1, 4'b0011, 0, 4'b0010, 1, "lock_release");
`endif

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
